// File: rtl/aes_128_sched_if.sv
// Requester/response bundle for the two-port AES-128 scheduler.
// The master side presents plaintext and consumes ciphertext responses.
interface aes_128_sched_if;
  logic         req0_valid;
  logic         req1_valid;
  logic [127:0] req0_data;
  logic [127:0] req1_data;
  logic         req0_ready;
  logic         req1_ready;
  logic         resp_valid;
  logic         resp_id;
  logic [127:0] resp_data;

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/aes_128_sched.sv
// Two-requester round-robin front end for a fixed-latency AES-128 core.
// A tag shift register tracks each issued block so responses return in order.
module aes_128_sched #(
  parameter int LATENCY = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  aes_128_sched_if.slave                  bus,
  input  logic                            key_we,
  input  logic                            key_sel,
  input  logic [127:0]                    key_data,
  output logic [127:0]                    core_state,
  output logic [127:0]                    core_key,
  input  logic [127:0]                    core_out,
  output logic [$clog2(LATENCY+2)-1:0]    inflight,
  output logic                            busy
);

  localparam int CW = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          grant_valid_s;
  logic          grant_id_s;
  logic          accept_s;
  logic          tag_exit_s;
  logic [CW-1:0] inflight_nxt_s;

  logic          last_grant_r;
  logic [127:0]  key_slot_r [2];
  logic [127:0]  core_state_r;
  logic [127:0]  core_key_r;
  logic [LATENCY:0] tag_v_r;
  logic [LATENCY:0] tag_id_r;
  logic          resp_valid_r;
  logic          resp_id_r;
  logic [127:0]  resp_data_r;
  logic [CW-1:0] inflight_r;
  logic          busy_r;

  // Round-robin grant; ties go to the requester not granted last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    case ({bus.req1_valid, bus.req0_valid})
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_id_s    = ~last_grant_r;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    endcase
  end

  // Ready is held low while reset is asserted even if valid is high.
  always_comb begin
    accept_s       = grant_valid_s & rst_n;
    bus.req0_ready = accept_s & ~grant_id_s;
    bus.req1_ready = accept_s & grant_id_s;
  end

  assign tag_exit_s = tag_v_r[LATENCY];

  // Occupancy tracks tags in the pipe; retire happens on the edge that raises resp_valid.
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({accept_s, tag_exit_s})
      2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
      2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Key slot storage; an issue on the same edge still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_slot_r[0] <= 128'd0;
      key_slot_r[1] <= 128'd0;
    end else if (key_we) begin
      key_slot_r[key_sel] <= key_data;
    end
  end

  // Issue register toward the core plus the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_state_r <= 128'd0;
      core_key_r   <= 128'd0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      core_state_r <= grant_id_s ? bus.req1_data : bus.req0_data;
      core_key_r   <= key_slot_r[grant_id_s];
      last_grant_r <= grant_id_s;
    end
  end

  // Tag pipeline mirrors the core latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_r  <= '0;
      tag_id_r <= '0;
    end else begin
      tag_v_r  <= {tag_v_r[LATENCY-1:0], accept_s};
      tag_id_r <= {tag_id_r[LATENCY-1:0], grant_id_s};
    end
  end

  // Response capture and occupancy status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_data_r  <= 128'd0;
      inflight_r   <= '0;
      busy_r       <= 1'b0;
    end else begin
      resp_valid_r <= tag_exit_s;
      if (tag_exit_s) begin
        resp_id_r   <= tag_id_r[LATENCY];
        resp_data_r <= core_out;
      end
      inflight_r <= inflight_nxt_s;
      busy_r     <= (inflight_nxt_s != '0);
    end
  end

  assign core_state     = core_state_r;
  assign core_key       = core_key_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_data  = resp_data_r;
  assign inflight       = inflight_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_aes_128_sched.sv
// Scoreboard bench for aes_128_sched with a stand-in fixed-latency core.
module tb_aes_128_sched;
  localparam int LAT = 20;
  localparam int CW  = $clog2(LAT + 2);

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] KEY_B    = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KEY_C    = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_we;
  logic          key_sel;
  logic [127:0]  key_data;
  logic [127:0]  core_state;
  logic [127:0]  core_key;
  logic [127:0]  core_out;
  logic [CW-1:0] inflight;
  logic          busy;

  aes_128_sched_if bus ();

  aes_128_sched #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .key_we   (key_we),
    .key_sel  (key_sel),
    .key_data (key_data),
    .core_state (core_state),
    .core_key (core_key),
    .core_out (core_out),
    .inflight (inflight),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Stand-in core: the FIPS-197 vector maps to its known ciphertext, other
  // inputs to a keyed swap so that a wrong key or block is visible.
  function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {s[63:0], s[127:64]} ^ k;
  endfunction

  logic [127:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_f(core_state, core_key);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  typedef struct {
    logic         id;
    logic [127:0] data;
    int           t_acc;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           run_len = 0;
  int           max_run = 0;
  int           max_infl = 0;
  logic [127:0] key_model [2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pop the oldest expectation whenever a response appears.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (bus.resp_valid === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL resp_unexpected: got resp_valid=1 id=%0d, expected no response", bus.resp_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_id", 128'(bus.resp_id), 128'(e.id));
          chk("resp_data", bus.resp_data, e.data);
          chk("resp_latency", 128'(cyc - e.t_acc), 128'(LAT + 1));
        end
      end else begin
        run_len = 0;
      end
      if (int'(inflight) > max_infl) max_infl = int'(inflight);
    end
  end

  // One cycle of stimulus; exp_g is the hand-derived grant {req1, req0}.
  task automatic drive(input logic v0, input logic v1,
                       input logic [127:0] d0, input logic [127:0] d1,
                       input logic kwe, input logic ksel, input logic [127:0] kd,
                       input logic [1:0] exp_g);
    exp_t e;
    @(negedge clk);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_data  = d0;
    bus.req1_data  = d1;
    key_we   = kwe;
    key_sel  = ksel;
    key_data = kd;
    #1;
    chk("grant", 128'({bus.req1_ready, bus.req0_ready}), 128'(exp_g));
    if (exp_g == 2'b01) begin
      e.id = 1'b0; e.data = core_f(d0, key_model[0]); e.t_acc = cyc + 1;
      sb.push_back(e);
    end else if (exp_g == 2'b10) begin
      e.id = 1'b1; e.data = core_f(d1, key_model[1]); e.t_acc = cyc + 1;
      sb.push_back(e);
    end
    if (kwe) key_model[ksel] = kd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 128'd0, 128'd0, 1'b0, 1'b0, 128'd0, 2'b00);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 128'({bus.req1_ready, bus.req0_ready}), 128'd0);
    chk({tag, "_resp_valid"}, 128'(bus.resp_valid), 128'd0);
    chk({tag, "_resp_id"}, 128'(bus.resp_id), 128'd0);
    chk({tag, "_resp_data"}, bus.resp_data, 128'd0);
    chk({tag, "_core_state"}, core_state, 128'd0);
    chk({tag, "_core_key"}, core_key, 128'd0);
    chk({tag, "_inflight"}, 128'(inflight), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data = 128'd0; bus.req1_data = 128'd0;
    key_we = 1'b0; key_sel = 1'b0; key_data = 128'd0;
    key_model[0] = 128'd0; key_model[1] = 128'd0;

    repeat (3) @(negedge clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk_reset_outputs("por");
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Tie after reset alternates starting with requester 0.
    max_run = 0;
    drive(1'b1, 1'b1, 128'h10, 128'h11, 1'b0, 1'b0, 128'd0, 2'b01);
    drive(1'b1, 1'b1, 128'h20, 128'h21, 1'b0, 1'b0, 128'd0, 2'b10);
    drive(1'b1, 1'b1, 128'h30, 128'h31, 1'b0, 1'b0, 128'd0, 2'b01);
    drive(1'b1, 1'b1, 128'h40, 128'h41, 1'b0, 1'b0, 128'd0, 2'b10);
    idle();
    wait_drain(40);
    chk("tie_consecutive", 128'(max_run), 128'd4);

    // Known-answer block through slot 0.
    drive(1'b0, 1'b0, 128'd0, 128'd0, 1'b1, 1'b0, FIPS_KEY, 2'b00);
    drive(1'b1, 1'b0, FIPS_PT, 128'd0, 1'b0, 1'b0, 128'd0, 2'b01);
    idle();
    chk("fips_inflight_1", 128'(inflight), 128'd1);
    chk("fips_busy_1", 128'(busy), 128'd1);
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("fips_resp_valid", 128'(bus.resp_valid), 128'd1);
    chk("fips_resp_data", bus.resp_data, FIPS_CT);
    chk("fips_inflight_0", 128'(inflight), 128'd0);
    chk("fips_busy_0", 128'(busy), 128'd0);
    wait_drain(40);

    // Key write colliding with an issue from the same slot.
    drive(1'b1, 1'b0, 128'hc0c0, 128'd0, 1'b1, 1'b0, KEY_B, 2'b01);
    drive(1'b1, 1'b0, 128'hc1c1, 128'd0, 1'b0, 1'b0, 128'd0, 2'b01);
    chk("issue0_state", core_state, 128'hc0c0);
    chk("issue0_old_key", core_key, FIPS_KEY);
    idle();
    chk("issue1_state", core_state, 128'hc1c1);
    chk("issue1_new_key", core_key, KEY_B);
    idle();
    chk("idle_hold_state", core_state, 128'hc1c1);
    chk("idle_hold_key", core_key, KEY_B);
    wait_drain(40);

    // Requester 1 through slot 1.
    drive(1'b0, 1'b0, 128'd0, 128'd0, 1'b1, 1'b1, KEY_C, 2'b00);
    drive(1'b0, 1'b1, 128'd0, 128'h5151_0000_abcd, 1'b0, 1'b0, 128'd0, 2'b10);
    idle();
    chk("req1_key", core_key, KEY_C);
    wait_drain(40);

    // Back-to-back stream from requester 0.
    max_run = 0;
    max_infl = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b0, 128'(i * 7 + 3), 128'd0, 1'b0, 1'b0, 128'd0, 2'b01);
      if (i == 25) begin
        chk("stream_inflight_sat", 128'(inflight), 128'(LAT + 1));
        chk("stream_busy", 128'(busy), 128'd1);
      end
    end
    idle();
    wait_drain(60);
    chk("stream_consecutive", 128'(max_run), 128'd30);
    chk("stream_max_inflight", 128'(max_infl), 128'(LAT + 1));

    // Reset with five blocks in flight.
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b0, 128'(i + 100), 128'd0, 1'b0, 1'b0, 128'd0, 2'b01);
    idle();
    chk("pre_reset_inflight", 128'(inflight), 128'd5);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk_reset_outputs("mid");
    sb.delete();
    key_model[0] = 128'd0; key_model[1] = 128'd0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) idle();
    drive(1'b1, 1'b1, 128'he0e0, 128'he1e1, 1'b0, 1'b0, 128'd0, 2'b01);
    idle();
    wait_drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_128_sched.md
AES_128_SCHED -- requirements
Module: aes_128_sched

Interface
REQ-001 Parameter LATENCY, default 20, SHALL be the cycle count from core_state/core_key sampled by the aes_128 core to the matching core_out.
REQ-002 Port clk  input  1  sole clock; every register SHALL be rising-edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Ports req0_valid, req1_valid  input  1  requester n presents a plaintext block.
REQ-005 Ports req0_data, req1_data  input  128  plaintext block for requester n.
REQ-006 Ports req0_ready, req1_ready  output  1  requester n's block is accepted this cycle.
REQ-007 Port key_we  input  1  write enable for a key slot.
REQ-008 Port key_sel  input  1  key slot to write (0 or 1).
REQ-009 Port key_data  input  128  key value to write.
REQ-010 Ports core_state, core_key  output  128  registered drive to aes_128 state/key.
REQ-011 Port core_out  input  128  aes_128 ciphertext.
REQ-012 Port resp_valid  output  1  resp_data is valid this cycle.
REQ-013 Port resp_id  output  1  requester that owns the response.
REQ-014 Port resp_data  output  128  ciphertext.
REQ-015 Port inflight  output  $clog2(LATENCY+2)  number of blocks issued and not yet returned.
REQ-016 Port busy  output  1  high when inflight is non-zero.

Function
REQ-017 Key slots: two 128-bit registers; key_we=1 SHALL load key_data into slot key_sel at the clock edge.
REQ-018 Arbitration SHALL be round-robin with a 1-bit last-grant pointer: with one requester valid, that requester is granted; with both valid, the requester other than the last granted wins.
REQ-019 reqN_ready SHALL equal the combinational grant: at most one ready is high per cycle, and ready is never high without the matching valid.
REQ-020 Handshake: valid&ready at edge T SHALL be an accept, and the pointer SHALL update to the granted id.
REQ-021 Issue: on accept at edge T, core_state SHALL equal reqN_data and core_key SHALL equal slot N from edge T.
REQ-022 Idle cycles: core_state and core_key SHALL hold their previous values.
REQ-023 Key write/issue collision: an issue in the same cycle as a write to its slot SHALL use the old key; the next issue SHALL use the new key.
REQ-024 Tag pipeline: a shift register of LATENCY+1 entries SHALL carry {valid, id}; entry 0 is loaded at each edge with the accept flag and grant id.
REQ-025 Response: when the tag exits the pipeline, resp_valid SHALL be high for exactly one cycle, with resp_id equal to the tag id and resp_data equal to core_out registered.
REQ-026 Latency: a block accepted at edge T SHALL produce resp_valid in the cycle after edge T+LATENCY+1.
REQ-027 Responses SHALL return in issue order; with no backpressure, throughput SHALL be one block per cycle.
REQ-028 inflight SHALL increment on accept, decrement on resp_valid, and hold when both occur in the same cycle.
REQ-029 inflight SHALL never exceed LATENCY+1.

Reset
REQ-030 rst_n low SHALL asynchronously clear the following: all tags, inflight, busy, resp_valid, resp_id, resp_data, core_state, core_key, and both key slots to 0; it SHALL set the pointer to 1 so requester 0 wins the first tie.
REQ-031 Reset mid-operation SHALL discard in-flight blocks; no resp_valid SHALL occur for blocks accepted before reset.
REQ-032 While rst_n is low, req0_ready and req1_ready SHALL be 0.

Verification
REQ-033 Load slot 0 with 2b7e1516_28aed2a6_abf71588_09cf4f3c; req0 sends 3243f6a8_885a308d_313198a2_e0370734, accepted at edge T -> after edge T+21: resp_valid=1, resp_id=0, resp_data=3925841d_02dc09fb_dc118597_196a0b32; inflight 1 -> 0.
REQ-034 Both requesters valid for 4 cycles after reset -> grants 0,1,0,1; 4 responses with ids 0,1,0,1 on consecutive cycles.
REQ-035 Back-to-back req0 for 30 cycles -> inflight saturates at 21, busy=1, and 30 consecutive resp_valid cycles in order.
REQ-036 key_we with key_sel=0 in the same cycle as a req0 accept -> that block is encrypted with the old key, and the following block uses the new key.
REQ-037 Issue 5 blocks, then assert rst_n low for 1 cycle at inflight=5 -> all outputs are 0, no resp_valid follows, and the first tie after reset goes to req0.
